// File: rtl/square_pkg.sv
// Shared types and default timing for the Oric tape-input square-wave decoder.
// Thresholds are in clk cycles of the 16 MHz system clock.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  // Result of measuring one low phase.
  typedef enum logic [1:0] {
    CLS_ERR   = 2'd0,
    CLS_SHORT = 2'd1,
    CLS_LONG  = 2'd2
  } cls_t;

  // Nominal half-period T: the tape-out accumulator adds STP=3356 to a 24-bit
  // phase each clk, so one wrap takes 2^24/3356 ~= 4999 clk, rounded to 5000.
  localparam int unsigned T_NOM   = 5000;
  localparam int unsigned T_MIN   = 2500;
  localparam int unsigned T_SPLIT = 7500;
  localparam int unsigned T_MAX   = 12500;
  localparam int unsigned CW      = 16;

  // Snapshot of the decoder's internal state for checkers and probes.
  typedef struct packed {
    state_t     state;
    logic       half;
    logic [2:0] nbit;
    logic       level;
  } dbg_t;

  function automatic cls_t classify(input int unsigned c,
                                    input int unsigned tmin,
                                    input int unsigned tsplit,
                                    input int unsigned tmax);
    if (c < tmin)        return CLS_ERR;
    else if (c < tsplit) return CLS_SHORT;
    else if (c <= tmax)  return CLS_LONG;
    return CLS_ERR;
  endfunction

endpackage

// File: rtl/tape_edge_sync.sv
// Brings the asynchronous tape level into the clk domain and flags its edges.
// All flops reset to 1 because the line idles high.
module tape_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/square_dec.sv
// Recovers LSB-first bytes from the tape square wave by timing low phases:
// two short lows (T) make a 1, one long low (2T) makes a 0.
module square_dec #(
  parameter int unsigned T_MIN   = square_pkg::T_MIN,
  parameter int unsigned T_SPLIT = square_pkg::T_SPLIT,
  parameter int unsigned T_MAX   = square_pkg::T_MAX,
  parameter int unsigned CW      = square_pkg::CW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               din,
  output logic [7:0]         data,
  output logic               valid,
  output logic               err,
  output logic               busy,
  output square_pkg::dbg_t   dbg
);

  import square_pkg::*;

  localparam logic [CW-1:0] CNT_TO  = CW'(T_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          level;
  logic          rise;
  logic          fall;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          half;
  logic [2:0]    nbit;
  logic [7:0]    shreg;

  cls_t          cls;
  logic          bit_ok;
  logic          bit_val;
  logic          half_set;
  logic          frame_err;
  logic [7:0]    new_shreg;

  tape_edge_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  // Decode what the current cycle means; the FSM below only applies it.
  always_comb begin
    cls       = classify(32'(cnt), T_MIN, T_SPLIT, T_MAX);
    bit_ok    = 1'b0;
    bit_val   = 1'b0;
    half_set  = 1'b0;
    frame_err = 1'b0;
    if (en) begin
      case (state)
        LOW: begin
          // A rising edge in the timeout cycle is still classified.
          if (rise) begin
            case (cls)
              CLS_SHORT: begin
                if (half) begin
                  bit_ok  = 1'b1;
                  bit_val = 1'b1;
                end else begin
                  half_set = 1'b1;
                end
              end
              CLS_LONG: begin
                if (half) frame_err = 1'b1;
                else      bit_ok    = 1'b1;
              end
              default: frame_err = 1'b1;
            endcase
          end else if (cnt == CNT_TO) begin
            frame_err = 1'b1;
          end
        end
        HIGH: begin
          if (!fall && cnt == CNT_TO) frame_err = 1'b1;
        end
        default: ;
      endcase
    end
    new_shreg = {bit_val, shreg[7:1]};
  end

  // valid/err are single-cycle strobes with no back-pressure: the consumer must
  // take data in the cycle valid is high, and data then holds until the next byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      half  <= 1'b0;
      nbit  <= '0;
      shreg <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        half  <= 1'b0;
        nbit  <= '0;
        shreg <= '0;
      end else begin
        if (rise || fall)                         cnt <= '0;
        else if (state != IDLE && cnt != {CW{1'b1}}) cnt <= cnt + CNT_ONE;

        if (frame_err) begin
          err   <= 1'b1;
          half  <= 1'b0;
          nbit  <= '0;
          shreg <= '0;
          state <= IDLE;
        end else if (bit_ok) begin
          shreg <= new_shreg;
          half  <= 1'b0;
          if (nbit == 3'd7) begin
            data  <= new_shreg;
            valid <= 1'b1;
            nbit  <= '0;
            state <= IDLE;
          end else begin
            nbit  <= nbit + 3'd1;
            state <= HIGH;
          end
        end else if (half_set) begin
          half  <= 1'b1;
          state <= HIGH;
        end else begin
          case (state)
            IDLE:    if (fall) state <= LOW;
            HIGH:    if (fall) state <= LOW;
            LOW:     state <= LOW;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign dbg  = '{state: state, half: half, nbit: nbit, level: level};

endmodule

// File: tb/tb_square_dec.sv
// Directed bench for square_dec with thresholds scaled by 1/100 (T=50 clk).
// Table of clean/jittered bytes, plus hand sequences for error and control cases.
module tb_square_dec;
  import square_pkg::*;

  localparam int unsigned TB_T_MIN   = 25;
  localparam int unsigned TB_T_SPLIT = 75;
  localparam int unsigned TB_T_MAX   = 125;
  localparam int unsigned TB_CW      = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       busy;
  dbg_t       dbg;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    int         sa;
    int         sb;
    int         la;
    int         lb;
    int         gap;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  square_dec #(
    .T_MIN   (TB_T_MIN),
    .T_SPLIT (TB_T_SPLIT),
    .T_MAX   (TB_T_MAX),
    .CW      (TB_CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .din     (din),
    .data    (data),
    .valid   (valid),
    .err     (err),
    .busy    (busy),
    .dbg     (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every valid pops one expected byte
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid || err) check("valid_err_excl", 32'(valid & err), 32'd0);
      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(data), 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          check("scoreboard_data", 32'(data), 32'(mon_exp));
        end
      end
      if (err) err_cnt++;
    end
  end

  // driver tasks; each starts and ends 1 time unit after a rising clk edge
  task automatic drive_phase(input logic lvl, input int n);
    din = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic final_high(input int d);
    din = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_hold", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("busy_drop", 32'(busy), 32'd0);
    check("valid_at_n2", 32'(valid), 32'd1);
    repeat (d - 3) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb,
                           input int sa, input int sb, input int la, input int lb);
    int ph;
    int d;
    int np;
    ph = 0;
    for (int i = 0; i < nb; i++) begin
      np = b[i] ? 4 : 2;
      for (int h = 0; h < np; h++) begin
        if (b[i]) d = ph[1] ? sb : sa;
        else      d = ph[1] ? lb : la;
        ph++;
        if (nb == 8 && i == nb - 1 && h == np - 1) final_high(d);
        else drive_phase(h[0], d);
      end
    end
  endtask

  int v0;
  int e0;
  int k;
  logic found;

  initial begin
    vecs[0] = '{8'hA5, 50, 50, 100, 100, 20,   8'hA5};
    vecs[1] = '{8'h00, 50, 50, 100, 100, 1000, 8'h00};
    vecs[2] = '{8'hFF, 50, 50, 100, 100, 20,   8'hFF};
    vecs[3] = '{8'h3C, 30, 70, 80,  125, 20,   8'h3C};
    vecs[4] = '{8'h96, 50, 50, 126, 126, 20,   8'h96};
    vecs[5] = '{8'h69, 26, 74, 76,  126, 20,   8'h69};

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(IDLE));
    reset_n = 1'b1;
    en = 1'b1;
    drive_phase(1'b1, 20);

    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      exp_q.push_back(vecs[i].exp_data);
      send_bits(vecs[i].b, 8, vecs[i].sa, vecs[i].sb, vecs[i].la, vecs[i].lb);
      drive_phase(1'b1, vecs[i].gap);
      check("vec_valid_count", 32'(valid_cnt - v0), 32'd1);
      check("vec_err_count", 32'(err_cnt - e0), 32'd0);
      check("vec_data", 32'(data), 32'(vecs[i].exp_data));
    end

    // short low then long low: half-bit mismatch
    e0 = err_cnt;
    v0 = valid_cnt;
    drive_phase(1'b0, 50);
    drive_phase(1'b1, 50);
    drive_phase(1'b0, 100);
    drive_phase(1'b1, 50);
    check("short_long_err", 32'(err_cnt - e0), 32'd1);
    check("short_long_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("short_long_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 8, 50, 50, 100, 100);
    drive_phase(1'b1, 20);
    check("resync_data", 32'(data), 32'h5A);

    // glitch low
    e0 = err_cnt;
    drive_phase(1'b0, 5);
    drive_phase(1'b1, 100);
    check("glitch_err", 32'(err_cnt - e0), 32'd1);

    // low one cycle past T_MAX: edge lands on the timeout cycle, single err
    e0 = err_cnt;
    drive_phase(1'b0, TB_T_MAX + 2);
    drive_phase(1'b1, 100);
    check("edge_at_timeout_err", 32'(err_cnt - e0), 32'd1);

    // stuck low: err when cnt reaches T_MAX+1, nothing at the later rise
    e0 = err_cnt;
    din = 1'b0;
    k = 0;
    found = 1'b0;
    for (int i = 1; i <= 400 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (err) begin
        found = 1'b1;
        k = i;
      end
    end
    check("stuck_low_err_time", 32'(k), 32'(TB_T_MAX + 5));
    @(posedge clk);
    #1;
    drive_phase(1'b0, 60);
    drive_phase(1'b1, 100);
    check("stuck_low_single_err", 32'(err_cnt - e0), 32'd1);

    // reset mid-byte
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'hC3, 4, 50, 50, 100, 100);
    check("busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_phase(1'b1, 20);
    check("reset_data_cleared", 32'(data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("reset_no_err", 32'(err_cnt - e0), 32'd0);
    exp_q.push_back(8'h81);
    send_bits(8'h81, 8, 50, 50, 100, 100);
    drive_phase(1'b1, 20);
    check("after_reset_data", 32'(data), 32'h81);

    // enable dropped mid-byte
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'hC3, 4, 50, 50, 100, 100);
    check("busy_before_en_drop", 32'(busy), 32'd1);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("en_drop_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    en = 1'b1;
    drive_phase(1'b1, 20);
    check("en_drop_data_kept", 32'(data), 32'h81);
    check("en_drop_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("en_drop_no_err", 32'(err_cnt - e0), 32'd0);
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 8, 50, 50, 100, 100);
    drive_phase(1'b1, 20);
    check("after_en_data", 32'(data), 32'hC3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
